lfsr_gen: RTL and testbench
===========================

// Module: lfsr_gen
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random source, generalising the fixed 16-bit LFSR.
//  Adds configurable width/taps, multi-bit advance per cycle, enable, run-time reseed,
//  zero-seed protection and a period-wrap pulse. Feeds game randomness and BIST patterns.
// PARAMETERS
//  WIDTH        16        state width in bits, 3..32
//  TAPS         16'hB400  feedback mask; bit i set => q[i] XORed into feedback (x^16+x^14+x^13+x^11+1)
//  STEPS        1         single-bit shifts performed per enabled cycle, 1..WIDTH
//  DEFAULT_SEED 16'h0001  reset state; also substitutes any all-zero seed; must be nonzero
// PORTS
//  clk_in     in   1      system clock, all logic on posedge
//  rst_in     in   1      synchronous reset, ACTIVE-LOW (0 = reset)
//  seed_in    in   WIDTH  seed value, sampled when load_in=1
//  load_in    in   1      load seed_in into state and start register
//  en_in      in   1      advance state by STEPS shifts this cycle
//  q_out      out  WIDTH  current LFSR state (registered)
//  rand_out   out  STEPS  feedback bits generated in last advance; bit 0 = first generated
//  valid_out  out  1      1 cycle after an accepted advance; qualifies rand_out
//  wrap_out   out  1      1-cycle pulse: last advance returned state to start register
// BEHAVIOUR
//  - Single shift: fb = ^(q & TAPS); q_next = {q[WIDTH-2:0], fb}.
//  - Advance = STEPS single shifts unrolled combinationally in one cycle; rand_out[k] = fb of shift k.
//  - Reset (rst_in=0 at posedge): q_out=DEFAULT_SEED, start=DEFAULT_SEED, rand_out=0,
//    valid_out=0, wrap_out=0. Reset mid-sequence discards state; no partial advance.
//  - Priority per cycle: reset > load_in > en_in.
//  - load_in=1: q_out and start <= (seed_in==0 ? DEFAULT_SEED : seed_in);
//    valid_out=0, wrap_out=0 next cycle; en_in ignored that cycle.
//  - en_in=1 (no load): q_out <= advanced state; rand_out <= fb bits; valid_out<=1;
//    wrap_out <= (advanced state == start). Latency 1 cycle.
//  - en_in=0: q_out, rand_out hold; valid_out<=0; wrap_out<=0.
//  - wrap_out asserts on every return to start, repeating each period
//    (period 2^WIDTH-1 single shifts for a maximal TAPS).
//  - All-zero state is unreachable: reset and load never produce it, a nonzero state
//    never shifts to zero. No lockup recovery logic is required.
//  - WIDTH/STEPS out of range, or DEFAULT_SEED==0: elaboration-time $error.
//  - All arithmetic is bitwise XOR; no carries. Output widths exactly as listed.
// TESTING
//  1 Reset: rst_in=0 two cycles -> q_out=16'h0001, valid_out=0, wrap_out=0.
//  2 Single step: defaults, 10 en cycles -> q_out=16'h0400; 11th -> q_out=16'h0801,
//    rand_out=1, valid_out=1.
//  3 Full period: en_in held 1 from reset -> wrap_out first pulses after exactly 65535
//    advances; no repeated state before then (scoreboard bitmap); pulses again at 131070.
//  4 Zero seed: load_in=1, seed_in=0 -> q_out=16'h0001 next cycle; never reaches 0.
//  5 Priority/reset mid-run: load_in=1 and en_in=1 with seed 16'hACE1 -> q_out=16'hACE1,
//    valid_out=0; rst_in=0 during run -> q_out=16'h0001 next cycle.
//  6 Multi-step: STEPS=4 vs STEPS=1 reference model over 1000 cycles -> q_out matches
//    reference every 4th shift; rand_out equals the 4 reference fb bits in order.

Source files
------------

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR: multi-shift advance per enable, run-time reseed with
// zero-seed substitution, and a pulse each time the state returns to its start value.
module lfsr_gen #(
    parameter int              WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter int              STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             load_in,
    input  logic             en_in,
    output logic [WIDTH-1:0] q_out,
    output logic [STEPS-1:0] rand_out,
    output logic             valid_out,
    output logic             wrap_out
);

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be in 3..32");
        end
        if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
            $error("lfsr_gen: STEPS must be in 1..WIDTH");
        end
        if (DEFAULT_SEED == '0) begin : g_bad_seed
            $error("lfsr_gen: DEFAULT_SEED must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] start;
    logic [STEPS-1:0] rand_bits;
    logic             valid;
    logic             wrap;

    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] advanced;
    logic [STEPS-1:0] fb_bits;
    logic [WIDTH-1:0] seed_ok;

    // Unrolled chain of single shifts; fb_bits[0] is the first bit generated.
    always_comb begin
        stage   = state;
        fb_bits = '0;
        for (int k = 0; k < STEPS; k++) begin
            fb_bits[k] = ^(stage & TAPS);
            stage      = {stage[WIDTH-2:0], fb_bits[k]};
        end
        advanced = stage;
    end

    // An all-zero seed would lock the register up, so it is replaced.
    assign seed_ok = (seed_in == '0) ? DEFAULT_SEED : seed_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= DEFAULT_SEED;
            start     <= DEFAULT_SEED;
            rand_bits <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else if (load_in) begin
            state <= seed_ok;
            start <= seed_ok;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (en_in) begin
            state     <= advanced;
            rand_bits <= fb_bits;
            valid     <= 1'b1;
            wrap      <= (advanced == start);
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
        end
    end

    assign q_out     = state;
    assign rand_out  = rand_bits;
    assign valid_out = valid;
    assign wrap_out  = wrap;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed + randomized bench for lfsr_gen: three instances (16-bit x1, 16-bit x4,
// 5-bit x1) tracked against an arithmetic single-shift reference model.
module tb_lfsr_gen;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] start;
        logic [31:0] rnd;
        logic        valid;
        logic        wrap;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: defaults
    logic        rst_a = 1'b0, load_a = 1'b0, en_a = 1'b0;
    logic [15:0] seed_a = '0;
    logic [15:0] q_a;
    logic [0:0]  rand_a;
    logic        valid_a, wrap_a;

    // instance B: four shifts per advance
    logic        rst_b = 1'b0, load_b = 1'b0, en_b = 1'b0;
    logic [15:0] seed_b = '0;
    logic [15:0] q_b;
    logic [3:0]  rand_b;
    logic        valid_b, wrap_b;

    // instance C: 5-bit maximal LFSR, short period of 31
    logic        rst_c = 1'b0, load_c = 1'b0, en_c = 1'b0;
    logic [4:0]  seed_c = '0;
    logic [4:0]  q_c;
    logic [0:0]  rand_c;
    logic        valid_c, wrap_c;

    lfsr_gen dut_a (
        .clk_in(clk), .rst_in(rst_a), .seed_in(seed_a), .load_in(load_a), .en_in(en_a),
        .q_out(q_a), .rand_out(rand_a), .valid_out(valid_a), .wrap_out(wrap_a)
    );

    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .STEPS(4), .DEFAULT_SEED(16'h0001)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .seed_in(seed_b), .load_in(load_b), .en_in(en_b),
        .q_out(q_b), .rand_out(rand_b), .valid_out(valid_b), .wrap_out(wrap_b)
    );

    lfsr_gen #(.WIDTH(5), .TAPS(5'h14), .STEPS(1), .DEFAULT_SEED(5'h01)) dut_c (
        .clk_in(clk), .rst_in(rst_c), .seed_in(seed_c), .load_in(load_c), .en_in(en_c),
        .q_out(q_c), .rand_out(rand_c), .valid_out(valid_c), .wrap_out(wrap_c)
    );

    model_t ma = '0, mb = '0, mc = '0;
    bit seen [0:65535];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one shift = parity of tapped bits appended at the bottom, top bit dropped.
    task automatic model_step(inout model_t m, input logic rst, input logic load,
                              input logic en, input logic [31:0] seed, input int w,
                              input int steps, input logic [31:0] taps,
                              input logic [31:0] dseed);
        logic [31:0] mask;
        logic [31:0] fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        if (!rst) begin
            m.q = dseed; m.start = dseed; m.rnd = '0; m.valid = 1'b0; m.wrap = 1'b0;
        end else if (load) begin
            m.q     = ((seed & mask) == 0) ? dseed : (seed & mask);
            m.start = m.q;
            m.valid = 1'b0; m.wrap = 1'b0;
        end else if (en) begin
            m.rnd = '0;
            for (int k = 0; k < steps; k++) begin
                fb       = 32'($countones(m.q & taps) % 2);
                m.rnd[k] = fb[0];
                m.q      = ((m.q << 1) | fb) & mask;
            end
            m.valid = 1'b1;
            m.wrap  = (m.q == m.start);
        end else begin
            m.valid = 1'b0; m.wrap = 1'b0;
        end
    endtask

    task automatic tick();
        logic ra, la, ea, rb, lb, eb, rc, lc, ec;
        logic [31:0] sa, sb, sc;
        ra = rst_a; la = load_a; ea = en_a; sa = 32'(seed_a);
        rb = rst_b; lb = load_b; eb = en_b; sb = 32'(seed_b);
        rc = rst_c; lc = load_c; ec = en_c; sc = 32'(seed_c);
        @(posedge clk);
        #1;
        model_step(ma, ra, la, ea, sa, 16, 1, 32'hB400, 32'h1);
        model_step(mb, rb, lb, eb, sb, 16, 4, 32'hB400, 32'h1);
        model_step(mc, rc, lc, ec, sc, 5, 1, 32'h14, 32'h1);
    endtask

    task automatic check_a(input string tag);
        check({tag, ".q"}, 32'(q_a), ma.q);
        check({tag, ".rand"}, 32'(rand_a), ma.rnd);
        check({tag, ".valid"}, 32'(valid_a), 32'(ma.valid));
        check({tag, ".wrap"}, 32'(wrap_a), 32'(ma.wrap));
    endtask

    initial begin
        // 1: reset held two cycles
        tick(); tick();
        check("reset.q", 32'(q_a), 32'h0001);
        check("reset.valid", 32'(valid_a), 32'h0);
        check("reset.wrap", 32'(wrap_a), 32'h0);
        check_a("reset");

        // 2: ten single shifts reach 0x0400, the eleventh produces a 1
        rst_a = 1'b1; en_a = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("step10.q", 32'(q_a), 32'h0400);
        check_a("step10");
        tick();
        check("step11.q", 32'(q_a), 32'h0801);
        check("step11.rand", 32'(rand_a), 32'h1);
        check("step11.valid", 32'(valid_a), 32'h1);

        // 5: load beats enable, then a mid-run reset
        load_a = 1'b1; en_a = 1'b1; seed_a = 16'hACE1;
        tick();
        check("prio.q", 32'(q_a), 32'hACE1);
        check("prio.valid", 32'(valid_a), 32'h0);
        load_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en_a = 1'($urandom_range(0, 1));
            tick();
            check_a("run_acе1");
        end
        rst_a = 1'b0; en_a = 1'b1;
        tick();
        check("midrst.q", 32'(q_a), 32'h0001);
        check("midrst.valid", 32'(valid_a), 32'h0);
        rst_a = 1'b1;

        // 4: zero seed substitution, then random load/enable traffic
        load_a = 1'b1; seed_a = 16'h0000; en_a = 1'b0;
        tick();
        check("zseed.q", 32'(q_a), 32'h0001);
        for (int i = 0; i < 200; i++) begin
            load_a = ($urandom_range(0, 15) == 0);
            seed_a = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            en_a   = 1'($urandom_range(0, 1));
            tick();
            check_a("rand_a");
            check("nonzero", 32'(q_a != 16'h0), 32'h1);
        end
        load_a = 1'b0;

        // 3: full period from reset; each state unique until the first wrap
        rst_a = 1'b0; en_a = 1'b0;
        tick();
        rst_a = 1'b1; en_a = 1'b1;
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            check("period.wrap", 32'(wrap_a), (i == 65535) ? 32'h1 : 32'h0);
            if (i < 65535) begin
                if (seen[q_a] || q_a == 16'h0) check("period.unique", 32'(q_a), 32'hFFFF_FFFF);
                seen[q_a] = 1'b1;
            end
        end
        check("period.q", 32'(q_a), 32'h0001);
        check_a("period_end");
        for (int i = 0; i < 100; i++) begin
            tick();
            check_a("period2");
        end
        en_a = 1'b0;

        // 6: four shifts per advance against the single-shift model
        rst_b = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rst_b  = ($urandom_range(0, 199) != 0);
            load_b = ($urandom_range(0, 31) == 0);
            seed_b = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            en_b   = ($urandom_range(0, 3) != 0);
            tick();
            check("m4.q", 32'(q_b), mb.q);
            check("m4.rand", 32'(rand_b), mb.rnd);
            check("m4.valid", 32'(valid_b), 32'(mb.valid));
            check("m4.wrap", 32'(wrap_b), 32'(mb.wrap));
        end
        rst_b = 1'b0;

        // short period: wrap repeats every 31 advances
        rst_c = 1'b1; en_c = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            check("w5.wrap", 32'(wrap_c), (i % 31 == 0) ? 32'h1 : 32'h0);
            check("w5.q", 32'(q_c), mc.q);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
